// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA sync alignment block
// Exports default coordinate widths, the maximum alignment delay,
// the {hs, vs, de} sync vector and the lock FSM state type.
package vga_pkg;
  localparam int XWidthDefault = 11;
  localparam int YWidthDefault = 10;
  localparam int MaxAlignDelay = 15;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_vec_t;
  typedef enum logic {
    SEEK,
    RUN
  } align_state_e;
endpackage

// File: rtl/vga_sync_align_if.sv
// vga_sync_align_if: timing-flag inputs and aligned video outputs of vga_sync_align
// master: drives pix_en and the raw h/v de/syn/eol flags, receives outputs.
// slave:  consumes the flags, drives x/y/act/sof, hsync/vsync/de and err.
interface vga_sync_align_if
  import vga_pkg::*;
#(
  parameter int X_WIDTH = XWidthDefault,
  parameter int Y_WIDTH = YWidthDefault
);
  logic pix_en;
  logic h_de;
  logic h_syn;
  logic h_eol;
  logic v_de;
  logic v_syn;
  logic v_eol;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic act;
  logic sof;
  logic hsync;
  logic vsync;
  logic de;
  logic err;
  modport master (
    output pix_en, h_de, h_syn, h_eol, v_de, v_syn, v_eol,
    input  x, y, act, sof, hsync, vsync, de, err
  );
  modport slave (
    input  pix_en, h_de, h_syn, h_eol, v_de, v_syn, v_eol,
    output x, y, act, sof, hsync, vsync, de, err
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: clock-enabled shift register with asynchronous reset value
// clk_i/rst_ni: clock, async active-low reset to RESET_VAL in every stage.
// en: advance strobe; d: stage input; q: last stage (d itself when DEPTH == 0).
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage <= {DEPTH{RESET_VAL}};
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_sync_align.sv
// vga_sync_align: frame-locked pixel coordinates and delay-aligned sync/de outputs
// clk_i/rst_ni: pixel clock, async active-low reset.
// vid (slave): pix_en + raw h/v de/syn/eol in; x/y/act/sof coordinates,
// polarity-applied hsync/vsync/de trailing by DELAY strobes, sticky err out.
module vga_sync_align
  import vga_pkg::*;
#(
  parameter int   X_WIDTH    = XWidthDefault,
  parameter int   Y_WIDTH    = YWidthDefault,
  parameter int   DELAY      = 2,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input logic             clk_i,
  input logic             rst_ni,
  vga_sync_align_if.slave vid
);
  align_state_e state_q, state_d;
  logic [X_WIDTH-1:0] x_cnt, x_d, x_q;
  logic [Y_WIDTH-1:0] y_cnt, y_d, y_q;
  logic run, line_end, accept, x_full, y_full, err_set;
  logic act_q, sof_q, err_q;
  sync_vec_t raw, sync_q, sync_dl;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEEK;
    else state_q <= state_d;
  end
  // Lock on the frame boundary; once running, only reset returns to SEEK.
  always_comb begin
    run      = state_q == RUN;
    state_d  = (!run && vid.pix_en && vid.h_eol && vid.v_eol) ? RUN : state_q;
    line_end = run && vid.pix_en && vid.h_eol;
    // Line end wins over a simultaneous de, so that pixel is dropped.
    accept   = run && vid.pix_en && vid.h_de && vid.v_de && !vid.h_eol;
    x_full   = &x_cnt;
    y_full   = &y_cnt;
    x_d      = line_end ? '0 : (accept && !x_full) ? x_cnt + 1'b1 : x_cnt;
    y_d      = !line_end ? y_cnt : vid.v_eol ? '0 : (vid.v_de && !y_full) ? y_cnt + 1'b1 : y_cnt;
    err_set  = (accept && x_full) || (line_end && vid.v_de && !vid.v_eol && y_full) ||
               (run && vid.h_de && vid.h_eol);
    raw      = run ? {vid.h_syn, vid.v_syn, vid.h_de && vid.v_de} : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      act_q  <= 1'b0;
      sof_q  <= 1'b0;
      err_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      x_cnt <= x_d;
      y_cnt <= y_d;
      act_q <= accept;
      sof_q <= accept && x_cnt == '0 && y_cnt == '0;
      err_q <= err_q || err_set;
      if (accept) begin
        x_q <= x_cnt;
        y_q <= y_cnt;
      end
      if (vid.pix_en) sync_q <= raw;
    end
  end
  // Stages hold the pre-polarity vector, so an all-zero reset is the inactive level.
  vga_delay_line #(
    .WIDTH    ($bits(sync_vec_t)),
    .DEPTH    (DELAY),
    .RESET_VAL('0)
  ) u_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (vid.pix_en),
    .d     (sync_q),
    .q     (sync_dl)
  );
  assign vid.x     = x_q;
  assign vid.y     = y_q;
  assign vid.act   = act_q;
  assign vid.sof   = sof_q;
  assign vid.err   = err_q;
  assign vid.hsync = sync_dl.hs ^ ~H_SYNC_POL;
  assign vid.vsync = sync_dl.vs ^ ~V_SYNC_POL;
  assign vid.de    = sync_dl.de;
endmodule

// File: tb/tb_vga_sync_align.sv
// tb_vga_sync_align: directed checks of lock, raster, delay, gating, polarity and error
module tb_vga_sync_align;
  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, ovr = 1'b0;
  logic h_de, h_syn, h_eol, v_de, v_syn, v_eol;
  int hc = 0, vc = 0, h_vis = 8, h_tot = 12;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // Frame: h_vis visible, 1 front porch, 2 sync, eol on last; 4 visible lines, sync line 5, eol line 6.
  assign h_de  = (hc < h_vis) || ovr;
  assign h_syn = (hc == h_vis + 1) || (hc == h_vis + 2);
  assign h_eol = (hc == h_tot - 1) || ovr;
  assign v_de  = vc < 4;
  assign v_syn = vc == 5;
  assign v_eol = vc == 6;
  vga_sync_align_if #(.X_WIDTH(11), .Y_WIDTH(10)) ia ();
  vga_sync_align_if #(.X_WIDTH(11), .Y_WIDTH(10)) ib ();
  vga_sync_align_if #(.X_WIDTH(3), .Y_WIDTH(10)) ic ();
  assign ia.pix_en = pix_en, ia.h_de = h_de, ia.h_syn = h_syn, ia.h_eol = h_eol,
         ia.v_de = v_de, ia.v_syn = v_syn, ia.v_eol = v_eol;
  assign ib.pix_en = pix_en, ib.h_de = h_de, ib.h_syn = h_syn, ib.h_eol = h_eol,
         ib.v_de = v_de, ib.v_syn = v_syn, ib.v_eol = v_eol;
  assign ic.pix_en = pix_en, ic.h_de = h_de, ic.h_syn = h_syn, ic.h_eol = h_eol,
         ic.v_de = v_de, ic.v_syn = v_syn, ic.v_eol = v_eol;
  vga_sync_align #(.DELAY(2)) dut_a (.clk_i(clk), .rst_ni(rst_n), .vid(ia));
  vga_sync_align #(.DELAY(3), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .vid(ib));
  vga_sync_align #(.X_WIDTH(3), .DELAY(0)) dut_c (.clk_i(clk), .rst_ni(rst_n), .vid(ic));
  task automatic tick(input logic pe);
    pix_en = pe;
    @(posedge clk);
    #1;
    if (pe) begin
      hc = (hc == h_tot - 1) ? 0 : hc + 1;
      if (hc == 0) vc = (vc == 6) ? 0 : vc + 1;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick(1);
    tick(1);
    checks++; if (ia.x !== 0 || ia.y !== 0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", ia.x, ia.y); end
    checks++; if (ia.act !== 1'b0 || ia.sof !== 1'b0) begin errors++; $display("FAIL reset_act_sof got %b%b want 00", ia.act, ia.sof); end
    checks++; if (ia.de !== 1'b0 || ia.err !== 1'b0) begin errors++; $display("FAIL reset_de_err got %b%b want 00", ia.de, ia.err); end
    checks++; if (ia.hsync !== 1'b1 || ia.vsync !== 1'b1) begin errors++; $display("FAIL reset_sync_a got %b%b want 11", ia.hsync, ia.vsync); end
    checks++; if (ib.hsync !== 1'b0 || ib.vsync !== 1'b1) begin errors++; $display("FAIL reset_sync_pol got %b%b want 01", ib.hsync, ib.vsync); end
  endtask
  task automatic test_lock;
    int lock_t = 0, act_t = 0;
    logic bnd;
    hc = 3;
    vc = 1;
    rst_n = 1'b1;
    for (int t = 1; t <= 100 && act_t == 0; t++) begin
      bnd = (hc == h_tot - 1) && (vc == 6);
      tick(1);
      if (bnd && lock_t == 0) lock_t = t;
      if (ia.act) act_t = t;
    end
    checks++; if (lock_t != 69) begin errors++; $display("FAIL lock_tick got %0d want 69", lock_t); end
    checks++; if (act_t != 70) begin errors++; $display("FAIL first_act_tick got %0d want 70", act_t); end
    checks++; if (ia.x !== 0 || ia.y !== 0 || ia.sof !== 1'b1) begin errors++; $display("FAIL first_pixel got x%0d y%0d sof%b want x0 y0 sof1", ia.x, ia.y, ia.sof); end
  endtask
  task automatic test_full_frame;
    int ex = 0, ey = 0, nact = 0, nsof = 0;
    for (int i = 0; i < 100 && !(hc == 0 && vc == 0); i++) tick(1);
    for (int t = 0; t < 84; t++) begin
      tick(1);
      if (ia.act) begin
        nact++;
        checks++; if (ia.x !== ex || ia.y !== ey || ia.sof !== (ex == 0 && ey == 0)) begin
          errors++; $display("FAIL raster got x%0d y%0d sof%b want x%0d y%0d", ia.x, ia.y, ia.sof, ex, ey);
        end
        ex = (ex == 7) ? 0 : ex + 1;
        if (ex == 0) ey++;
      end
      if (ia.sof) nsof++;
    end
    checks++; if (nact != 32) begin errors++; $display("FAIL frame_acts got %0d want 32", nact); end
    checks++; if (nsof != 1) begin errors++; $display("FAIL frame_sofs got %0d want 1", nsof); end
  endtask
  task automatic test_delay;
    int b_act = 0, b_de = 0, a_de = 0, de_run = 0, hs_run = 0, hs_cnt = 0, vs_cnt = 0, a_hs_cnt = 0;
    logic de_done = 1'b0, hs_done = 1'b0;
    for (int t = 1; t <= 84; t++) begin
      tick(1);
      if (ib.act && b_act == 0) b_act = t;
      if (ib.de && b_de == 0) b_de = t;
      if (ia.de && a_de == 0) a_de = t;
      if (ib.de && !de_done) de_run++; else if (de_run > 0) de_done = 1'b1;
      if (ib.hsync && !hs_done) hs_run++; else if (hs_run > 0) hs_done = 1'b1;
      if (ib.hsync) hs_cnt++;
      if (!ib.vsync) vs_cnt++;
      if (!ia.hsync) a_hs_cnt++;
    end
    checks++; if (b_act != 1 || b_de != 4) begin errors++; $display("FAIL delay3_lag got act%0d de%0d want act1 de4", b_act, b_de); end
    checks++; if (a_de != 3) begin errors++; $display("FAIL delay2_de got %0d want 3", a_de); end
    checks++; if (de_run != 8) begin errors++; $display("FAIL de_per_line got %0d want 8", de_run); end
    checks++; if (hs_run != 2) begin errors++; $display("FAIL hsync_width got %0d want 2", hs_run); end
    checks++; if (hs_cnt != 14) begin errors++; $display("FAIL hsync_pol_high got %0d want 14", hs_cnt); end
    checks++; if (vs_cnt != 12) begin errors++; $display("FAIL vsync_pol_low got %0d want 12", vs_cnt); end
    checks++; if (a_hs_cnt != 14) begin errors++; $display("FAIL hsync_a_low got %0d want 14", a_hs_cnt); end
  endtask
  task automatic test_gating;
    int ex = 0, ey = 0, nact = 0, a_act = 0, a_de = 0;
    logic [10:0] px;
    logic [9:0] py;
    logic pde, phs, pvs;
    for (int i = 1; i <= 168; i++) begin
      px = ia.x; py = ia.y; pde = ia.de; phs = ia.hsync; pvs = ia.vsync;
      tick(i % 2 == 1);
      if (ia.act && a_act == 0) a_act = i;
      if (ia.de && a_de == 0) a_de = i;
      if (i % 2 == 0) begin
        checks++; if (ia.act !== 1'b0 || ia.sof !== 1'b0 || ia.x !== px || ia.y !== py ||
                      ia.de !== pde || ia.hsync !== phs || ia.vsync !== pvs) begin
          errors++; $display("FAIL idle_hold tick %0d got act%b x%0d y%0d de%b want act0 x%0d y%0d de%b", i, ia.act, ia.x, ia.y, ia.de, px, py, pde);
        end
      end else if (ia.act) begin
        nact++;
        checks++; if (ia.x !== ex || ia.y !== ey) begin errors++; $display("FAIL gated_raster got x%0d y%0d want x%0d y%0d", ia.x, ia.y, ex, ey); end
        ex = (ex == 7) ? 0 : ex + 1;
        if (ex == 0) ey++;
      end
    end
    checks++; if (nact != 32) begin errors++; $display("FAIL gated_acts got %0d want 32", nact); end
    checks++; if (a_act != 1 || a_de != 5) begin errors++; $display("FAIL gated_lag got act%0d de%0d want act1 de5", a_act, a_de); end
  endtask
  task automatic test_async_reset;
    int nact = 0;
    for (int i = 0; i < 100 && !(hc == 5 && vc == 1); i++) tick(1);
    checks++; if (ia.x !== 4 || ia.y !== 1 || ia.de !== 1'b1) begin errors++; $display("FAIL pre_reset got x%0d y%0d de%b want x4 y1 de1", ia.x, ia.y, ia.de); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ia.x !== 0 || ia.y !== 0 || ia.de !== 1'b0) begin errors++; $display("FAIL async_clear got x%0d y%0d de%b want x0 y0 de0", ia.x, ia.y, ia.de); end
    checks++; if (ia.hsync !== 1'b1 || ib.hsync !== 1'b0 || ib.vsync !== 1'b1) begin errors++; $display("FAIL async_sync got %b%b%b want 101", ia.hsync, ib.hsync, ib.vsync); end
    #1 rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick(1);
      if (ia.act) nact++;
    end
    checks++; if (nact != 0) begin errors++; $display("FAIL seek_after_reset got %0d acts want 0", nact); end
  endtask
  task automatic test_saturation;
    rst_n = 1'b0;
    h_vis = 10;
    h_tot = 14;
    hc = 13;
    vc = 6;
    #1 rst_n = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick(1);
      if (t == 8) begin
        checks++; if (ic.x !== 3'd6 || ic.err !== 1'b0) begin errors++; $display("FAIL sat_before got x%0d err%b want x6 err0", ic.x, ic.err); end
      end
      if (t == 9) begin
        checks++; if (ic.x !== 3'd7 || ic.err !== 1'b1) begin errors++; $display("FAIL sat_hit got x%0d err%b want x7 err1", ic.x, ic.err); end
      end
      if (t == 11) begin
        checks++; if (ic.x !== 3'd7 || ic.act !== 1'b1 || ia.x !== 9) begin errors++; $display("FAIL sat_stick got x%0d act%b wide_x%0d want x7 act1 wide_x9", ic.x, ic.act, ia.x); end
      end
    end
    for (int t = 0; t < 100; t++) tick(1);
    checks++; if (ic.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", ic.err); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ic.err !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", ic.err); end
  endtask
  task automatic test_de_eol_err;
    h_vis = 8;
    h_tot = 12;
    hc = 11;
    vc = 6;
    #1 rst_n = 1'b1;
    tick(1);
    tick(1);
    tick(1);
    checks++; if (ia.err !== 1'b0 || ia.x !== 1) begin errors++; $display("FAIL pre_conflict got err%b x%0d want err0 x1", ia.err, ia.x); end
    ovr = 1'b1;
    tick(1);
    ovr = 1'b0;
    checks++; if (ia.act !== 1'b0 || ia.err !== 1'b1) begin errors++; $display("FAIL de_eol_conflict got act%b err%b want act0 err1", ia.act, ia.err); end
    tick(1);
    checks++; if (ia.act !== 1'b1 || ia.x !== 0 || ia.y !== 1) begin errors++; $display("FAIL after_conflict got act%b x%0d y%0d want act1 x0 y1", ia.act, ia.x, ia.y); end
  endtask
  initial begin
    test_reset;
    test_lock;
    test_full_frame;
    test_delay;
    test_gating;
    test_async_reset;
    test_saturation;
    test_de_eol_err;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
